// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: trace entry, region decode.
// Ports: none (package only).
package dmem_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } trace_entry_t;

    localparam logic [31:0] DEF_TOHOST_ADDR = 32'h0000_0FFC;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_TOHOST,
        REG_UNMAPPED
    } region_e;

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO of trace entries with a dropped-push flag.
// Ports: clk, reset, i_push/i_entry, i_pop, o_head, o_full, o_empty, o_drop.
module trace_fifo
    import dmem_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  trace_entry_t i_entry,
    input  logic         i_pop,
    output trace_entry_t o_head,
    output logic         o_full,
    output logic         o_empty,
    output logic         o_drop
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    trace_entry_t r_mem [DEPTH];

    logic w_pop;
    logic w_push;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    // A pop in the same cycle frees the head slot, so a push into a full
    // FIFO still fits when it coincides with a pop.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);
    assign o_drop = i_push & o_full & ~w_pop;

    assign o_head = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage is not reset; a store landing together with reset is discarded.
    always_ff @(posedge clk) begin
        if (w_push && !reset) r_mem[r_wptr[AW-1:0]] <= i_entry;
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-bus target: word RAM, tohost completion register, sticky flags, store trace.
// Ports: clk, reset, memwrite/dataadr/writedata -> readdata; trace_* drain port; flags.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          RAM_WORDS   = 64,
    parameter int          TRACE_DEPTH = 8,
    parameter logic [31:0] TOHOST_ADDR = DEF_TOHOST_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data,
    output logic        trace_overflow,
    output logic        misaligned,
    output logic        done,
    output logic [31:0] done_code
);

    localparam int          IW        = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    logic [31:0]  r_ram [RAM_WORDS];
    logic         r_done;
    logic [31:0]  r_done_code;
    logic         r_misaligned;
    logic         r_overflow;

    region_e      w_region;
    logic [IW-1:0] w_idx;
    logic         w_aligned;
    logic         w_accept;
    logic         w_misal;
    trace_entry_t w_entry;
    trace_entry_t w_head;
    logic         w_full;
    logic         w_empty;
    logic         w_drop;

    always_comb begin
        w_region = REG_UNMAPPED;
        if (dataadr < RAM_BYTES)
            w_region = REG_RAM;
        else if (dataadr == TOHOST_ADDR)
            w_region = REG_TOHOST;
    end

    assign w_idx     = dataadr[IW+1:2];
    assign w_aligned = (dataadr[1:0] == 2'b00);
    assign w_accept  = memwrite & w_aligned;
    assign w_misal   = memwrite & ~w_aligned;
    assign w_entry   = '{addr: dataadr, data: writedata};

    always_comb begin
        readdata = 32'h0;
        unique case (w_region)
            REG_RAM:      readdata = r_ram[w_idx];
            REG_TOHOST:   readdata = r_done_code;
            REG_UNMAPPED: readdata = 32'h0;
            default:      readdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept && !reset && w_region == REG_RAM)
            r_ram[w_idx] <= writedata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done       <= 1'b0;
            r_done_code  <= 32'h0;
            r_misaligned <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            // Only the first tohost store is kept as the completion code.
            if (w_accept && w_region == REG_TOHOST && !r_done) begin
                r_done      <= 1'b1;
                r_done_code <= writedata;
            end
            if (w_misal) r_misaligned <= 1'b1;
            if (w_drop)  r_overflow   <= 1'b1;
        end
    end

    trace_fifo #(
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_accept),
        .i_entry (w_entry),
        .i_pop   (trace_ready),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );

    // A dropped push can only ever happen against a full FIFO.
    always_ff @(posedge clk) begin
        if (!reset) assert (!w_drop || w_full);
    end

    assign trace_valid    = ~w_empty;
    assign trace_addr     = w_head.addr;
    assign trace_data     = w_head.data;
    assign trace_overflow = r_overflow;
    assign misaligned     = r_misaligned;
    assign done           = r_done;
    assign done_code      = r_done_code;

endmodule
